// File: rtl/cpu_pkg.sv
// Shared fetch-side types: reset PC default and the buffered fetch entry.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; the head is read directly from the storage registers,
// so the outputs never depend combinationally on push/pop.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_dat_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Flush wins over everything; a pop in the flush cycle has already been taken by the consumer.
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & ~flush_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues word reads, tracks in-flight PCs,
// buffers responses for decode and discards stale work after a redirect.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic [31:0] pc_4_o,
  input  logic        instr_ready_i
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int LW = CW + 1;

  logic [31:0]   fpc_q, fpc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;

  logic          grant, pop, accept;
  logic [LW-1:0] load;

  logic          pcl_push, pcl_full, pcl_empty;
  logic [31:0]   pcl_head;
  logic [CW-1:0] pcl_count;

  logic          q_full, q_empty;
  logic [CW-1:0] q_count;
  fetch_entry_t  q_push_dat, q_head;

  logic          fifo_flags_unused;

  assign pop    = instr_valid_o & instr_ready_i;
  assign grant  = imem_req_o & imem_gnt_i;
  // A head leaving this cycle frees its slot now, which keeps back-to-back fetch at one per cycle.
  assign load   = LW'(inflight_q) + LW'(q_count) - LW'(pop);
  assign imem_req_o  = reset_n & (load < LW'(QDEPTH));
  assign imem_addr_o = fpc_q;

  assign accept   = imem_rvalid_i & ~redirect_i & (drop_q == '0);
  assign pcl_push = grant & ~redirect_i;

  assign q_push_dat.instr = imem_rdata_i;
  assign q_push_dat.pc    = pcl_head;

  assign fifo_flags_unused = ^{pcl_full, pcl_empty, pcl_count, q_full};

  fetch_fifo #(.DEPTH(QDEPTH), .WIDTH(32)) u_pc_list (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (pcl_push),
    .push_dat_i (fpc_q),
    .pop_i      (accept),
    .flush_i    (redirect_i),
    .head_o     (pcl_head),
    .full_o     (pcl_full),
    .empty_o    (pcl_empty),
    .count_o    (pcl_count)
  );

  fetch_fifo #(.DEPTH(QDEPTH), .WIDTH($bits(fetch_entry_t))) u_instr_q (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (accept),
    .push_dat_i (q_push_dat),
    .pop_i      (pop),
    .flush_i    (redirect_i),
    .head_o     (q_head),
    .full_o     (q_full),
    .empty_o    (q_empty),
    .count_o    (q_count)
  );

  assign instr_valid_o = ~q_empty;
  assign instr_o       = q_head.instr;
  assign instr_pc_o    = q_head.pc;
  assign pc_4_o        = q_head.pc + 32'd4;

  always_comb begin
    fpc_d      = fpc_q;
    inflight_d = inflight_q + CW'(grant) - CW'(imem_rvalid_i);
    drop_d     = drop_q;
    if (redirect_i) begin
      fpc_d  = {redirect_pc_i[31:2], 2'b00};
      // Every request still outstanding after this cycle belongs to the old path.
      drop_d = inflight_d;
    end else begin
      if (grant) fpc_d = fpc_q + 32'd4;
      if (imem_rvalid_i && drop_q != '0) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fpc_q      <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fpc_q      <= fpc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Fetch unit bench: memory/decode driver, program-order reference model and scoreboard monitor.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam int          QD     = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        redirect_i, imem_gnt_i, imem_rvalid_i, instr_ready_i;
  logic [31:0] redirect_pc_i, imem_rdata_i;
  logic        imem_req_o, instr_valid_o;
  logic [31:0] imem_addr_o, instr_o, instr_pc_o, pc_4_o;

  always #10 clk = ~clk;

  fetch_unit #(.RESET_PC(RST_PC), .QDEPTH(QD)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .pc_4_o        (pc_4_o),
    .instr_ready_i (instr_ready_i)
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] dat; int due; } rsp_t;

  exp_t exp_q[$];
  rsp_t mem_q[$];

  int checks = 0, failures = 0, cyc = 0, pops = 0, last_due = 0;
  logic [31:0] fpc_m = RST_PC;
  int   gnt_mode = 0, lat_min = 1, lat_max = 1, rdy_mode = 0, rand_redir = 0;
  logic redir_pend = 1'b0, clear_pend = 1'b0;
  logic [31:0] redir_tgt = 32'h0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a ^ 32'hC3A5_5A3C) + {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Memory and decode driver; also advances the program-order model on each grant.
  initial begin
    logic [31:0] d;
    int due;
    redirect_i = 0; redirect_pc_i = 0; imem_gnt_i = 0;
    imem_rvalid_i = 0; imem_rdata_i = 0; instr_ready_i = 0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!reset_n) begin
        exp_q.delete(); mem_q.delete();
        fpc_m = RST_PC; last_due = 0; clear_pend = 0;
      end else if (clear_pend) begin
        exp_q.delete(); clear_pend = 0;
      end
      #2;
      case (rdy_mode)
        0:       instr_ready_i = 1'b1;
        1:       instr_ready_i = 1'b0;
        default: instr_ready_i = 1'($urandom_range(1));
      endcase
      redirect_i = 1'b0;
      if (reset_n && (redir_pend || (rand_redir != 0 && $urandom_range(15) == 0))) begin
        redirect_i    = 1'b1;
        redirect_pc_i = redir_pend ? redir_tgt : $urandom;
        redir_pend    = 1'b0;
      end
      #2;
      imem_rvalid_i = reset_n && mem_q.size() > 0 && mem_q[0].due == cyc;
      imem_rdata_i  = imem_rvalid_i ? mem_q[0].dat : $urandom;
      imem_gnt_i    = (gnt_mode == 0) ? 1'b1 : (gnt_mode == 1) ? 1'($urandom_range(1)) : 1'b0;
      #2;
      if (reset_n) begin
        if (imem_rvalid_i) void'(mem_q.pop_front());
        if (imem_req_o && imem_gnt_i) begin
          chk("grant_addr", imem_addr_o, fpc_m);
          d   = mem_data(imem_addr_o);
          due = cyc + $urandom_range(lat_max, lat_min);
          if (due <= last_due) due = last_due + 1;
          mem_q.push_back('{d, due});
          last_due = due;
          if (!redirect_i) exp_q.push_back('{fpc_m, mem_data(fpc_m)});
          fpc_m = fpc_m + 32'd4;
        end
        if (redirect_i) begin
          fpc_m      = {redirect_pc_i[31:2], 2'b00};
          clear_pend = 1'b1;
        end
      end
    end
  end

  // Scoreboard monitor: every instruction handed to decode must be the next expected one.
  always @(negedge clk) begin
    if (reset_n && instr_valid_o && instr_ready_i) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_pc", instr_pc_o, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_pc", instr_pc_o, e.pc);
        chk("sb_instr", instr_o, e.instr);
        chk("sb_pc4", pc_4_o, e.pc + 32'd4);
      end
      pops++;
    end
  end

  task automatic mid();
    @(posedge clk); #14;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; #1;
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_req",   32'(imem_req_o),    32'd0);
    chk("rst_instr", instr_o,    32'd0);
    chk("rst_pc",    instr_pc_o, 32'd0);
    chk("rst_pc4",   pc_4_o,     32'd4);
    mid(); mid();
    @(posedge clk); #1 reset_n = 1'b1; #13;
    chk("rel_req",  32'(imem_req_o), 32'd1);
    chk("rel_addr", imem_addr_o, RST_PC);
  endtask

  task automatic wait_valid(input string name, input int budget);
    for (int i = 0; i < budget && !instr_valid_o; i++) mid();
    chk(name, 32'(instr_valid_o), 32'd1);
  endtask

  initial begin
    int p0;
    #1;
    // Zero-wait memory, decode always ready.
    do_reset();
    chk("a_valid_c1", 32'(instr_valid_o), 32'd0);
    mid();
    chk("a_valid_c2", 32'(instr_valid_o), 32'd0);
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("a_valid_run", 32'(instr_valid_o), 32'd1);
      chk("a_pc_run", instr_pc_o, RST_PC + 32'(4 * i));
      chk("a_pc4_run", pc_4_o, RST_PC + 32'(4 * i + 4));
    end

    // Decode stalled: queue fills, fetch stops, then drains in order.
    rdy_mode = 1;
    do_reset();
    for (int i = 0; i < 6; i++) mid();
    chk("b_req_stalled", 32'(imem_req_o), 32'd0);
    chk("b_head_pc", instr_pc_o, RST_PC);
    rdy_mode = 0;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("b_drain_valid", 32'(instr_valid_o), 32'd1);
      chk("b_drain_pc", instr_pc_o, RST_PC + 32'(4 * i));
    end

    // Redirect with two slow fetches in flight.
    lat_min = 3; lat_max = 3;
    do_reset();
    mid();
    redir_tgt = 32'h0000_3401; redir_pend = 1'b1;
    mid();
    mid();
    chk("c_flush_valid", 32'(instr_valid_o), 32'd0);
    wait_valid("c_timeout", 40);
    chk("c_first_pc", instr_pc_o, 32'h0000_3400);

    // Redirect in the same cycle as the grant for 0x3008.
    lat_min = 1; lat_max = 1;
    do_reset();
    mid();
    redir_tgt = 32'h0000_5002; redir_pend = 1'b1;
    mid();
    chk("d_addr_in_redirect", imem_addr_o, 32'h0000_3008);
    chk("d_req_in_redirect", 32'(imem_req_o), 32'd1);
    mid();
    chk("d_flush_valid", 32'(instr_valid_o), 32'd0);
    wait_valid("d_timeout", 20);
    chk("d_first_pc", instr_pc_o, 32'h0000_5000);

    // Grant withheld for three cycles: request held, address stable.
    gnt_mode = 2;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("e_req_held", 32'(imem_req_o), 32'd1);
      chk("e_addr_held", imem_addr_o, fpc_m);
    end
    gnt_mode = 0;
    for (int i = 0; i < 8; i++) mid();

    // Reset with a full queue.
    rdy_mode = 1;
    for (int i = 0; i < 6; i++) mid();
    chk("f_full_valid", 32'(instr_valid_o), 32'd1);
    do_reset();
    rdy_mode = 0;
    wait_valid("f_timeout", 10);
    chk("f_first_pc", instr_pc_o, RST_PC);

    // Randomised traffic against the scoreboard.
    gnt_mode = 1; lat_min = 1; lat_max = 3; rdy_mode = 2; rand_redir = 1;
    p0 = pops;
    for (int i = 0; i < 3000; i++) mid();
    rand_redir = 0; gnt_mode = 0; rdy_mode = 0;
    chk("g_progress", 32'(pops - p0 > 200), 32'd1);
    for (int i = 0; i < 20; i++) mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
